lfsr_sample_fifo: RTL and testbench
===================================

# lfsr_sample_fifo

Downstream consumer of the 20-bit LFSR pseudo-random source in the FPGA interface path. Samples the LFSR output word at a programmable decimation rate, buffers samples in a small synchronous FIFO, and presents them to the host-side read logic with flags, a fill level and a sticky overflow indication. Capture runs under a start/stop/limit control FSM.

## Interface
- DATA_W, 20, sample width; matches LFSR output width
- DEPTH, 8, FIFO entries; power of 2, minimum 2
- DECIM_W, 8, width of decimation control
- CNT_W, 16, width of sample-count limit
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- data_in  in  DATA_W  LFSR output word
- start  in  1  single-cycle pulse; begin capture
- stop  in  1  single-cycle pulse; abort capture, return to IDLE
- decim  in  DECIM_W  sample every decim+1 cycles while capturing; static during capture
- count_limit  in  CNT_W  sample ticks before DONE; 0 = unlimited
- rd_en  in  1  host pop request
- clr_ovf  in  1  clear sticky overflow
- rd_data  out  DATA_W  popped word, registered
- rd_valid  out  1  one-cycle pulse, rd_data valid
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  log2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a sample was dropped
- busy  out  1  FSM in CAPTURE
- done  out  1  FSM in DONE

## Operation
- FSM states IDLE, CAPTURE, DONE; reset to IDLE.
- IDLE: start -> CAPTURE; decimation counter and sample counter cleared to 0.
- CAPTURE: decimation counter increments each cycle; when counter == decim a sample tick occurs, counter returns to 0. Each tick pushes data_in and increments sample counter. When count_limit != 0 and sample counter reaches count_limit -> DONE (last tick pushes).
- DONE: holds; start -> CAPTURE (counters cleared); stop -> IDLE.
- stop in any state -> IDLE. start and stop same cycle: stop wins.
- Tick while full and no pop that cycle: word dropped, overflow set; counter still increments. Tick while full with rd_en same cycle: push accepted, level unchanged.
- overflow held until clr_ovf or reset; a drop coincident with clr_ovf leaves overflow set.
- rd_en while empty: ignored, rd_valid stays 0, rd_data holds. rd_en when not empty: head popped.
- FIFO read/write pointers wrap modulo DEPTH; level = write count minus read count, range 0..DEPTH.
- Reset mid-capture: FIFO emptied, counters and flags cleared, FSM to IDLE immediately.

## Timing
- Reset values: rd_data 0, rd_valid 0, empty 1, full 0, level 0, overflow 0, busy 0, done 0.
- start sampled at edge E: busy = 1 from E. With decim=0, first tick is the first CAPTURE cycle; word stored = data_in at edge E+1.
- Ticks spaced exactly decim+1 cycles; first tick decim+1 cycles after CAPTURE entry.
- Push at edge E: level/empty/full update at E (visible the following cycle).
- Pop: rd_en high in cycle before edge E -> rd_data and rd_valid=1 after E; rd_valid low after E+1 unless another pop. Throughput one pop per cycle.
- done asserts the cycle after the final tick's edge; busy and done never both 1.

## Structure
- Shared package: DATA_W, default DEPTH, state encoding enum (IDLE=0, CAPTURE=1, DONE=2, 2-bit).
- Sub-module sync_fifo (DATA_W, DEPTH): storage, pointers, level, empty/full, registered read port. Top holds FSM, decimation/sample counters, overflow logic.

## Test plan
- Reset then idle: all outputs at reset values; rd_en with empty -> rd_valid stays 0.
- decim=0, count_limit=4, start: four consecutive pushes, done=1, level=4; four rd_en -> rd_data equals data_in at the four capture edges, in order.
- decim=2, count_limit=3: pushes at CAPTURE cycles 3, 6, 9; done after third; level=3.
- DEPTH=8, decim=0, count_limit=10, no reads: level=8, full=1, overflow=1, 2 words dropped; clr_ovf -> overflow=0; reads return first 8 samples.
- Full FIFO, tick and rd_en same cycle: push accepted, level stays 8, overflow stays 0, oldest word out.
- Unlimited capture, assert start+stop together -> FSM IDLE; assert reset mid-capture -> level=0, empty=1, busy=0 immediately.

Source files
------------

// File: rtl/lfsr_sample_fifo_pkg.sv
// Shared sizing constants, FSM state encoding and a width helper for the
// LFSR sample capture path.
package lfsr_sample_fifo_pkg;

    localparam int LSF_DATA_W  = 20;
    localparam int LSF_DEPTH   = 8;
    localparam int LSF_DECIM_W = 8;
    localparam int LSF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lfsr_sample_fifo_if.sv
// Control, sample and host read-side signals of the capture block.
// The master drives controls and the sample word; the slave is the capture block.
interface lfsr_sample_fifo_if
    import lfsr_sample_fifo_pkg::*;
#(
    parameter int DATA_W  = LSF_DATA_W,
    parameter int DEPTH   = LSF_DEPTH,
    parameter int DECIM_W = LSF_DECIM_W,
    parameter int CNT_W   = LSF_CNT_W
);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0]  data_in;
    logic               start;
    logic               stop;
    logic [DECIM_W-1:0] decim;
    logic [CNT_W-1:0]   count_limit;
    logic               rd_en;
    logic               clr_ovf;

    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;
    logic               empty;
    logic               full;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               busy;
    logic               done;

    modport master (
        output data_in, start, stop, decim, count_limit, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, level, overflow, busy, done
    );

    modport slave (
        input  data_in, start, stop, decim, count_limit, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, level, overflow, busy, done
    );

endinterface

// File: rtl/lfsr_sample_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count and a registered read port.
// Pushes while full are accepted only when a pop happens in the same cycle.
module sync_fifo
    import lfsr_sample_fifo_pkg::*;
#(
    parameter  int DATA_W = LSF_DATA_W,
    parameter  int DEPTH  = LSF_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int LVL_W  = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_d, rd_valid_q;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: storage is not reset; resetting the pointers and level already empties it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign level_o    = level_q;

endmodule

// File: rtl/lfsr_sample_fifo.sv
// Decimating sampler of the LFSR word: start/stop/limit capture FSM feeding a
// small FIFO, with a sticky overflow flag for dropped samples.
module lfsr_sample_fifo
    import lfsr_sample_fifo_pkg::*;
#(
    parameter int DATA_W  = LSF_DATA_W,
    parameter int DEPTH   = LSF_DEPTH,
    parameter int DECIM_W = LSF_DECIM_W,
    parameter int CNT_W   = LSF_CNT_W
) (
    input logic               clk,
    input logic               reset,
    lfsr_sample_fifo_if.slave bus
);

    state_e             state_q;
    logic [DECIM_W-1:0] decim_cnt_q;
    logic [CNT_W-1:0]   samp_cnt_q;
    logic [CNT_W-1:0]   samp_next;
    logic               busy_q, done_q;
    logic               overflow_q, overflow_d;
    logic               tick, limit_hit, push, drop, fifo_full;

    assign tick      = (state_q == ST_CAPTURE) && (decim_cnt_q == bus.decim);
    assign samp_next = samp_cnt_q + CNT_W'(1);
    assign limit_hit = (bus.count_limit != '0) && (samp_next == bus.count_limit);

    // A tick into a full FIFO survives only if the host frees a slot that cycle.
    assign push       = tick && (!fifo_full || bus.rd_en);
    assign drop       = tick && fifo_full && !bus.rd_en;
    assign overflow_d = drop || (overflow_q && !bus.clr_ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            decim_cnt_q <= '0;
            samp_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (bus.stop) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            state_q     <= ST_CAPTURE;
                            decim_cnt_q <= '0;
                            samp_cnt_q  <= '0;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (tick) begin
                            decim_cnt_q <= '0;
                            samp_cnt_q  <= samp_next;
                            if (limit_hit) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            decim_cnt_q <= decim_cnt_q + DECIM_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .wr_data_i  (bus.data_in),
        .pop_i      (bus.rd_en),
        .rd_data_o  (bus.rd_data),
        .rd_valid_o (bus.rd_valid),
        .empty_o    (bus.empty),
        .full_o     (fifo_full),
        .level_o    (bus.level)
    );

    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// Directed bench for lfsr_sample_fifo: capture, decimation, overflow, simultaneous
// push/pop on a full FIFO, stop priority and asynchronous reset.
module tb_lfsr_sample_fifo;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lfsr_sample_fifo_if bus ();

    lfsr_sample_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present d as the sample word for the coming edge; return 1 time unit after it.
    task automatic cyc(input logic [19:0] d);
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(20'h0);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [19:0] d2 [4];
        d2[0] = 20'h12345; d2[1] = 20'hABCDE; d2[2] = 20'h00001; d2[3] = 20'hFFFFF;

        bus.data_in = '0; bus.start = 0; bus.stop = 0; bus.decim = '0;
        bus.count_limit = '0; bus.rd_en = 0; bus.clr_ovf = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_level", bus.level, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        bus.rd_en = 1'b1;
        cyc(20'h0);
        bus.rd_en = 1'b0;
        check("idle_pop_valid", bus.rd_valid, 0);
        check("idle_pop_data", bus.rd_data, 0);

        // decim=0, limit=4: four back-to-back pushes
        bus.decim = 8'd0; bus.count_limit = 16'd4;
        pulse_start();
        check("t2_busy", bus.busy, 1);
        check("t2_level0", bus.level, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(d2[i]);
            check($sformatf("t2_level%0d", i + 1), bus.level, i + 1);
        end
        check("t2_done", bus.done, 1);
        check("t2_busy_off", bus.busy, 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(20'h0);
            check($sformatf("t2_rd_valid%0d", i), bus.rd_valid, 1);
            check($sformatf("t2_rd_data%0d", i), bus.rd_data, d2[i]);
        end
        bus.rd_en = 1'b0;
        cyc(20'h0);
        check("t2_valid_drop", bus.rd_valid, 0);
        check("t2_empty", bus.empty, 1);

        // decim=2, limit=3: ticks at capture cycles 3, 6, 9
        bus.decim = 8'd2; bus.count_limit = 16'd3;
        pulse_start();
        check("t3_busy", bus.busy, 1);
        check("t3_done_clr", bus.done, 0);
        for (int k = 1; k <= 9; k++) begin
            cyc(20'h30000 + 20'(k));
            check($sformatf("t3_level_c%0d", k), bus.level, k / 3);
        end
        check("t3_done", bus.done, 1);
        check("t3_busy_off", bus.busy, 0);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(20'h0);
            check($sformatf("t3_rd_data%0d", i), bus.rd_data, 20'h30000 + 20'(3 * i));
        end
        bus.rd_en = 1'b0;
        cyc(20'h0);
        check("t3_empty", bus.empty, 1);

        // decim=0, limit=10, no reads: 8 stored, 2 dropped; last drop coincides with clr_ovf
        bus.decim = 8'd0; bus.count_limit = 16'd10;
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            bus.clr_ovf = (k == 10);
            cyc(20'h40000 + 20'(k));
            check($sformatf("t4_level_c%0d", k), bus.level, (k > 8) ? 8 : k);
            check($sformatf("t4_full_c%0d", k), bus.full, k >= 8);
            check($sformatf("t4_ovf_c%0d", k), bus.overflow, k >= 9);
        end
        bus.clr_ovf = 1'b0;
        check("t4_done", bus.done, 1);
        bus.clr_ovf = 1'b1;
        cyc(20'h0);
        bus.clr_ovf = 1'b0;
        check("t4_ovf_cleared", bus.overflow, 0);
        check("t4_level_hold", bus.level, 8);

        // full FIFO: tick and pop in the same cycle
        bus.count_limit = 16'd1;
        pulse_start();
        bus.rd_en = 1'b1;
        cyc(20'h5A5A5);
        check("t5_rd_valid", bus.rd_valid, 1);
        check("t5_rd_oldest", bus.rd_data, 20'h40001);
        check("t5_level", bus.level, 8);
        check("t5_full", bus.full, 1);
        check("t5_ovf", bus.overflow, 0);
        check("t5_done", bus.done, 1);
        for (int i = 2; i <= 8; i++) begin
            cyc(20'h0);
            check($sformatf("t5_rd_data%0d", i), bus.rd_data, 20'h40000 + 20'(i));
        end
        cyc(20'h0);
        check("t5_rd_last", bus.rd_data, 20'h5A5A5);
        bus.rd_en = 1'b0;
        cyc(20'h0);
        check("t5_valid_low", bus.rd_valid, 0);
        check("t5_empty", bus.empty, 1);
        bus.rd_en = 1'b1;
        cyc(20'h0);
        bus.rd_en = 1'b0;
        check("t5_empty_pop_valid", bus.rd_valid, 0);
        check("t5_empty_pop_hold", bus.rd_data, 20'h5A5A5);

        // unlimited capture, start+stop together -> IDLE
        bus.count_limit = 16'd0;
        pulse_start();
        for (int k = 1; k <= 3; k++) cyc(20'h60000 + 20'(k));
        check("t6_busy", bus.busy, 1);
        check("t6_level", bus.level, 3);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(20'h0);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("t6_stop_busy", bus.busy, 0);
        check("t6_stop_done", bus.done, 0);
        cyc(20'h0);
        check("t6_stay_idle", bus.busy, 0);

        // asynchronous reset mid-capture
        pulse_start();
        cyc(20'h70001);
        cyc(20'h70002);
        check("t6_busy2", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_level", bus.level, 0);
        check("t6_rst_empty", bus.empty, 1);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_full", bus.full, 0);
        check("t6_rst_rd_data", bus.rd_data, 0);
        reset = 1'b0;
        cyc(20'h0);
        check("t6_post_busy", bus.busy, 0);
        check("t6_post_level", bus.level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
